// File: rtl/axis_mux_arb_if.sv
// rtl/axis_mux_arb_if.sv - stream bundle between the packet sources/sink and the packet mux
interface axis_mux_arb_if #(
    parameter int NUM_SOURCES = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int TID_WIDTH   = $clog2(NUM_SOURCES)
);
    logic [NUM_SOURCES-1:0]            s_valid;
    logic [NUM_SOURCES-1:0]            s_ready;
    logic [NUM_SOURCES-1:0]            s_last;
    logic [DATA_WIDTH*NUM_SOURCES-1:0] s_data;
    logic                              m_valid;
    logic                              m_ready;
    logic                              m_last;
    logic [DATA_WIDTH-1:0]             m_data;
    logic [TID_WIDTH-1:0]              m_tid;

    modport master (
        output s_valid, s_last, s_data, m_ready,
        input  s_ready, m_valid, m_last, m_data, m_tid
    );

    modport slave (
        input  s_valid, s_last, s_data, m_ready,
        output s_ready, m_valid, m_last, m_data, m_tid
    );
endinterface

// File: rtl/axis_mux_arb.sv
// rtl/axis_mux_arb.sv - N-input packet mux with per-source FIFOs, RR/fixed arbitration and truncation
module axis_mux_arb #(
    parameter int NUM_SOURCES   = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 8,
    parameter int ARB_MODE      = 0,
    parameter int MAX_PKT_BEATS = 0,
    parameter int TID_WIDTH     = $clog2(NUM_SOURCES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_SOURCES-1:0] srcEnable,
    axis_mux_arb_if.slave          bus,
    output logic [NUM_SOURCES-1:0] truncStrobe
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int SEL_W = $clog2(NUM_SOURCES);
    localparam int CNT_W = $clog2(MAX_PKT_BEATS + 2);
    localparam logic [CNT_W-1:0] TRUNC_AT = (MAX_PKT_BEATS > 0) ? CNT_W'(MAX_PKT_BEATS - 1) : '0;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    logic [DATA_WIDTH:0]    mem_q    [NUM_SOURCES][FIFO_DEPTH];
    logic [PTR_W:0]         wr_ptr_q [NUM_SOURCES];
    logic [PTR_W:0]         rd_ptr_q [NUM_SOURCES];
    logic [DATA_WIDTH:0]    head     [NUM_SOURCES];
    logic [NUM_SOURCES-1:0] full, empty, push, pop, eligible;

    state_t                 state_q, state_d;
    logic [SEL_W-1:0]       grant_q, grant_d, last_grant_q, last_grant_d, win;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   found, load;
    logic                   m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic [DATA_WIDTH-1:0]  m_data_q, m_data_d;
    logic [TID_WIDTH-1:0]   m_tid_q, m_tid_d;
    logic [NUM_SOURCES-1:0] trunc_q, trunc_d;

    // Pointers carry one extra wrap bit so full and empty are exact.
    always_comb begin
        for (int i = 0; i < NUM_SOURCES; i++) begin
            full[i]  = (wr_ptr_q[i] ^ rd_ptr_q[i]) == {1'b1, {PTR_W{1'b0}}};
            empty[i] = wr_ptr_q[i] == rd_ptr_q[i];
            head[i]  = mem_q[i][rd_ptr_q[i][PTR_W-1:0]];
        end
    end

    assign bus.s_ready = ~full & {NUM_SOURCES{rst_n}};
    assign push        = bus.s_valid & bus.s_ready;
    assign eligible    = ~empty & srcEnable;
    assign load        = !m_valid_q || bus.m_ready;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i][PTR_W-1:0]] <= {bus.s_last[i], bus.s_data[i*DATA_WIDTH +: DATA_WIDTH]};
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (!rst_n) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end else begin
                if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
                if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
            end
        end
    end

    // Round-robin searches upward from the source after the last grant.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NUM_SOURCES; k++) begin
            idx = (ARB_MODE == 0) ? (int'(last_grant_q) + 1 + k) % NUM_SOURCES : k;
            if (!found && eligible[SEL_W'(idx)]) begin
                found = 1'b1;
                win   = SEL_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= SEL_W'(NUM_SOURCES - 1);
            cnt_q        <= '0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            m_data_q     <= '0;
            m_tid_q      <= '0;
            trunc_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            m_data_q     <= m_data_d;
            m_tid_q      <= m_tid_d;
            trunc_q      <= trunc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        m_valid_d    = m_valid_q;
        m_last_d     = m_last_q;
        m_data_d     = m_data_q;
        m_tid_d      = m_tid_q;
        trunc_d      = '0;
        pop          = '0;
        if (load) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d      = win;
                    last_grant_d = win;
                    cnt_d        = '0;
                    state_d      = STREAM;
                end
            end
            STREAM: begin
                if (load && !empty[grant_q]) begin
                    pop[grant_q] = 1'b1;
                    m_valid_d    = 1'b1;
                    m_data_d     = head[grant_q][DATA_WIDTH-1:0];
                    m_tid_d      = TID_WIDTH'(grant_q);
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    if (head[grant_q][DATA_WIDTH]) begin
                        m_last_d = 1'b1;
                        state_d  = IDLE;
                    end else if (MAX_PKT_BEATS > 0 && cnt_q == TRUNC_AT) begin
                        m_last_d         = 1'b1;
                        trunc_d[grant_q] = 1'b1;
                        state_d          = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!empty[grant_q]) begin
                    pop[grant_q] = 1'b1;
                    if (head[grant_q][DATA_WIDTH]) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.m_valid = m_valid_q;
    assign bus.m_last  = m_last_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_tid   = m_tid_q;
    assign truncStrobe = trunc_q;
endmodule

// File: tb/tb_axis_mux_arb.sv
// tb/tb_axis_mux_arb.sv - self-checking bench for axis_mux_arb (RR, fixed priority, truncation)
module tb_axis_mux_arb;
    localparam int N  = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n = 1'b0;
    logic [N-1:0]    src_en = '1;
    logic [N-1:0]    s_valid = '0, s_last = '0;
    logic [DW*N-1:0] s_data = '0;
    logic            m_ready = 1'b1;
    int              sel = 0;
    logic [N-1:0]    trunc_a, trunc_b, trunc_c;

    axis_mux_arb_if #(.NUM_SOURCES(N), .DATA_WIDTH(DW), .TID_WIDTH(2)) ia ();
    axis_mux_arb_if #(.NUM_SOURCES(N), .DATA_WIDTH(DW), .TID_WIDTH(2)) ib ();
    axis_mux_arb_if #(.NUM_SOURCES(N), .DATA_WIDTH(DW), .TID_WIDTH(2)) ic ();

    assign ia.s_valid = s_valid; assign ia.s_last = s_last; assign ia.s_data = s_data; assign ia.m_ready = m_ready;
    assign ib.s_valid = s_valid; assign ib.s_last = s_last; assign ib.s_data = s_data; assign ib.m_ready = m_ready;
    assign ic.s_valid = s_valid; assign ic.s_last = s_last; assign ic.s_data = s_data; assign ic.m_ready = m_ready;

    axis_mux_arb #(.NUM_SOURCES(N), .DATA_WIDTH(DW), .FIFO_DEPTH(8), .ARB_MODE(0), .MAX_PKT_BEATS(0), .TID_WIDTH(2))
        dut_a (.clk(clk), .rst_n(rst_n), .srcEnable(src_en), .bus(ia.slave), .truncStrobe(trunc_a));
    axis_mux_arb #(.NUM_SOURCES(N), .DATA_WIDTH(DW), .FIFO_DEPTH(8), .ARB_MODE(1), .MAX_PKT_BEATS(0), .TID_WIDTH(2))
        dut_b (.clk(clk), .rst_n(rst_n), .srcEnable(src_en), .bus(ib.slave), .truncStrobe(trunc_b));
    axis_mux_arb #(.NUM_SOURCES(N), .DATA_WIDTH(DW), .FIFO_DEPTH(8), .ARB_MODE(0), .MAX_PKT_BEATS(3), .TID_WIDTH(2))
        dut_c (.clk(clk), .rst_n(rst_n), .srcEnable(src_en), .bus(ic.slave), .truncStrobe(trunc_c));

    logic          obs_m_valid, obs_m_last;
    logic [DW-1:0] obs_m_data;
    logic [1:0]    obs_m_tid;
    logic [N-1:0]  obs_s_ready, obs_trunc;

    always_comb begin
        case (sel)
            1: begin
                obs_m_valid = ib.m_valid; obs_m_last = ib.m_last; obs_m_data = ib.m_data;
                obs_m_tid = ib.m_tid; obs_s_ready = ib.s_ready; obs_trunc = trunc_b;
            end
            2: begin
                obs_m_valid = ic.m_valid; obs_m_last = ic.m_last; obs_m_data = ic.m_data;
                obs_m_tid = ic.m_tid; obs_s_ready = ic.s_ready; obs_trunc = trunc_c;
            end
            default: begin
                obs_m_valid = ia.m_valid; obs_m_last = ia.m_last; obs_m_data = ia.m_data;
                obs_m_tid = ia.m_tid; obs_s_ready = ia.s_ready; obs_trunc = trunc_a;
            end
        endcase
    end

    logic [DW:0] stim_q [N][$];
    logic [DW:0] exp_q  [N][$];
    int          order_q [$];
    int          trunc_seen [N];
    int          model_cnt [N];
    bit          model_drop [N];
    int          tests = 0, fails = 0;
    bit          in_pkt = 0, chk_gap = 0, have_prev = 0;
    int          cyc = 0, prev_beat_cyc = 0, last_end_cyc = 0, pkt_tid = 0, beats_seen = 0;
    time         last_acc_time [N];
    time         pkt_start_time = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference model: what the sink should see for each beat accepted into a source FIFO.
    function automatic void model_push(int i, logic [DW:0] b);
        if (sel != 2) begin
            exp_q[i].push_back(b);
            return;
        end
        if (model_drop[i]) begin
            if (b[DW]) begin
                model_drop[i] = 0;
                model_cnt[i]  = 0;
            end
            return;
        end
        model_cnt[i]++;
        if (b[DW]) begin
            exp_q[i].push_back(b);
            model_cnt[i] = 0;
        end else if (model_cnt[i] == 3) begin
            exp_q[i].push_back({1'b1, b[DW-1:0]});
            model_drop[i] = 1;
            model_cnt[i]  = 0;
        end else begin
            exp_q[i].push_back(b);
        end
    endfunction

    initial begin
        bit          acc [N];
        logic [DW:0] h;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                acc[i] = s_valid[i] && obs_s_ready[i];
                if (acc[i]) last_acc_time[i] = $time;
            end
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i] && stim_q[i].size() > 0) model_push(i, stim_q[i].pop_front());
                if (stim_q[i].size() > 0) begin
                    h = stim_q[i][0];
                    s_valid[i] = 1'b1;
                    s_last[i]  = h[DW];
                    s_data[i*DW +: DW] = h[DW-1:0];
                end else begin
                    s_valid[i] = 1'b0;
                end
            end
        end
    end

    initial begin
        bit          stalled;
        logic [35:0] saved;
        logic [DW:0] e;
        int          t;
        stalled = 0;
        saved   = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                stalled   = 0;
                in_pkt    = 0;
                have_prev = 0;
            end else begin
                for (int i = 0; i < N; i++) trunc_seen[i] += int'(obs_trunc[i]);
                if (stalled) check("stall_hold", {obs_m_valid, obs_m_last, obs_m_tid, obs_m_data}, saved);
                if (obs_m_valid && m_ready) begin
                    t = int'(obs_m_tid);
                    if (exp_q[t].size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_beat: tid %0d data %0h, expected no beat", t, obs_m_data);
                    end else begin
                        e = exp_q[t].pop_front();
                        check("beat_data", {obs_m_last, obs_m_data}, e);
                    end
                    if (!in_pkt) begin
                        order_q.push_back(t);
                        pkt_start_time = $time;
                        pkt_tid = t;
                        in_pkt  = 1;
                        if (chk_gap && have_prev) check("pkt_gap", cyc - last_end_cyc, 2);
                    end else begin
                        check("no_interleave", t, pkt_tid);
                        if (chk_gap) check("beat_contig", cyc - prev_beat_cyc, 1);
                    end
                    prev_beat_cyc = cyc;
                    beats_seen++;
                    if (obs_m_last) begin
                        in_pkt       = 0;
                        have_prev    = 1;
                        last_end_cyc = cyc;
                    end
                end
                stalled = obs_m_valid && !m_ready;
                saved   = {1'b1, obs_m_last, obs_m_tid, obs_m_data};
            end
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic clear_sb();
        for (int i = 0; i < N; i++) begin
            stim_q[i].delete();
            exp_q[i].delete();
            model_cnt[i]  = 0;
            model_drop[i] = 0;
            trunc_seen[i] = 0;
        end
        order_q.delete();
        beats_seen = 0;
        s_valid = '0;
    endtask

    task automatic do_reset(bit chk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        if (chk) check("rst_s_ready", obs_s_ready, 0);
        @(posedge clk); #2;
        if (chk) check("rst_outputs", {obs_m_valid, obs_m_last, obs_m_tid, obs_m_data, obs_trunc}, 0);
        clear_sb();
        rst_n = 1'b1;
    endtask

    task automatic push_pkt(int src, int len, logic [DW-1:0] base);
        logic [DW-1:0] d;
        for (int b = 0; b < len; b++) begin
            d = base + DW'(b);
            stim_q[src].push_back({(b == len - 1), d});
        end
    endtask

    function automatic bit sb_empty();
        bit r;
        r = !in_pkt;
        for (int i = 0; i < N; i++) r = r && stim_q[i].size() == 0 && exp_q[i].size() == 0;
        return r;
    endfunction

    task automatic wait_drain(string name, int limit);
        int k;
        k = 0;
        while (k < limit && !sb_empty()) begin
            tick(1);
            k++;
        end
        check(name, k < limit, 1);
        tick(3);
    endtask

    function automatic logic [63:0] order_word();
        logic [31:0] act;
        act = '0;
        for (int k = 0; k < order_q.size() && k < 8; k++) act[4*k +: 4] = 4'(order_q[k]);
        return {32'(order_q.size()), act};
    endfunction

    typedef struct {
        int          sel;
        logic [3:0]  en;
        logic [15:0] pkts;
        int          n;
        logic [31:0] order;
    } vec_t;

    initial begin
        vec_t vt [7];
        int   k;
        vt[0] = '{0, 4'hF, 16'h0012, 3, 32'h010};
        vt[1] = '{1, 4'hF, 16'h0012, 3, 32'h100};
        vt[2] = '{0, 4'hF, 16'h1120, 4, 32'h1321};
        vt[3] = '{1, 4'hF, 16'h1120, 4, 32'h3211};
        vt[4] = '{0, 4'b1011, 16'h1101, 2, 32'h30};
        vt[5] = '{1, 4'b0110, 16'h2111, 2, 32'h21};
        vt[6] = '{2, 4'hF, 16'h2001, 3, 32'h330};

        do_reset(1);

        // Arbitration table: packets queued behind a stalled sink, then released.
        for (int r = 0; r < 7; r++) begin
            sel = vt[r].sel;
            do_reset(0);
            src_en  = vt[r].en;
            m_ready = 1'b0;
            for (int s = 0; s < N; s++)
                for (int p = 0; p < int'(vt[r].pkts[4*s +: 4]); p++)
                    push_pkt(s, 2, DW'(32'h1000 * (r + 1) + 32'h100 * s + 32'h10 * p));
            tick(12);
            m_ready = 1'b1;
            tick(60);
            check($sformatf("arb_row%0d", r), order_word(), {32'(vt[r].n), vt[r].order});
        end

        // Basic ordering with 1-cycle gaps between packets.
        sel = 0;
        do_reset(0);
        src_en = 4'hF; m_ready = 1'b1; chk_gap = 1;
        for (int s = 0; s < N; s++) push_pkt(s, 4, 32'hCACA0000 + DW'(s * 16));
        wait_drain("order_drain", 200);
        chk_gap = 0;
        check("basic_order", order_word(), {32'd4, 32'h3210});

        // Fixed priority pre-empts a continuously streaming source at packet boundaries.
        sel = 1;
        do_reset(0);
        src_en = 4'hF; m_ready = 1'b0;
        for (int p = 0; p < 3; p++) push_pkt(3, 2, 32'h3000 + DW'(p * 16));
        tick(10);
        push_pkt(0, 2, 32'h0A00);
        push_pkt(1, 2, 32'h1A00);
        tick(10);
        m_ready = 1'b1;
        wait_drain("fp_drain", 200);
        check("fp_order", order_word(), {32'd5, 32'h33103});

        // Random backpressure over 200 packets.
        sel = 0;
        do_reset(0);
        src_en = 4'hF;
        for (int p = 0; p < 200; p++) push_pkt(p % 4, int'($urandom_range(1, 4)), $urandom);
        k = 0;
        while (k < 20000 && !sb_empty()) begin
            m_ready = 1'($urandom_range(0, 1));
            tick(1);
            k++;
        end
        check("bp_drain", k < 20000, 1);
        m_ready = 1'b1;
        tick(3);
        check("bp_pkts", order_q.size(), 200);
        m_ready = 1'b0;
        push_pkt(2, 12, 32'h2000);
        tick(20);
        check("fifo_full_ready", obs_s_ready, 4'b1011);
        m_ready = 1'b1;
        wait_drain("full_drain", 200);

        // Truncation to 3 beats with drain, then an exact-length packet.
        sel = 2;
        do_reset(0);
        src_en = 4'hF; m_ready = 1'b1;
        push_pkt(1, 6, 32'hD0);
        push_pkt(1, 3, 32'hE0);
        wait_drain("trunc_drain", 200);
        check("trunc_strobe1", trunc_seen[1], 1);
        check("trunc_others", trunc_seen[0] + trunc_seen[2] + trunc_seen[3], 0);
        check("trunc_beats", beats_seen, 6);
        check("trunc_pkts", order_q.size(), 2);

        // Enable mask blocks source 2 until it is re-enabled.
        sel = 0;
        do_reset(0);
        src_en = 4'b1011; m_ready = 1'b1;
        push_pkt(2, 4, 32'h2100);
        push_pkt(2, 4, 32'h2200);
        push_pkt(0, 2, 32'h0100);
        push_pkt(1, 2, 32'h1100);
        push_pkt(3, 2, 32'h3100);
        tick(40);
        check("mask_order", order_word(), {32'd3, 32'h310});
        check("mask_s_ready2", obs_s_ready[2], 0);
        src_en = 4'hF;
        wait_drain("mask_drain", 200);
        check("mask_release", order_word(), {32'd5, 32'h22310});

        // Reset mid-packet, then a fresh single-beat packet.
        sel = 0;
        do_reset(0);
        src_en = 4'hF; m_ready = 1'b1;
        push_pkt(1, 4, 32'h6000);
        k = 0;
        while (k < 50 && beats_seen < 2) begin
            tick(1);
            k++;
        end
        check("midpkt_reach", k < 50, 1);
        do_reset(1);
        #1;
        check("post_rst_ready", obs_s_ready, 4'hF);
        push_pkt(2, 1, 32'h7777);
        wait_drain("fresh_drain", 100);
        check("fresh_order", order_word(), {32'd1, 32'h2});
        check("latency", 64'(pkt_start_time - last_acc_time[2]), 30);
        tick(20);
        check("no_stale", beats_seen, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/axis_mux_arb.md
Name: axis_mux_arb

Overview:
- N-input AXI-Stream packet multiplexer for the Aurora user-clock domain.
- Merges FMPS/cell-controller packet streams into one output link.
- Each source has its own FIFO, and each packet is forwarded atomically.
- Generalises the existing single-mode mux with the following:
  - selectable round-robin or fixed-priority arbitration;
  - a per-source enable mask;
  - a source-ID sideband;
  - packet-length truncation with drain.

Parameters:
NUM_SOURCES, 4, number of input streams (2..16)
DATA_WIDTH, 32, tdata width
FIFO_DEPTH, 8, per-source FIFO depth in beats, power of 2, >=2
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
MAX_PKT_BEATS, 0, maximum forwarded beats per packet; 0 disables truncation
TID_WIDTH, $clog2(NUM_SOURCES), width of m_tid

Ports:
clk  in  1  Aurora user clock; all logic on rising edge
rst_n  in  1  synchronous reset, active low
srcEnable  in  NUM_SOURCES  per-source grant eligibility
s_valid  in  NUM_SOURCES  per-source tvalid
s_ready  out  NUM_SOURCES  per-source tready (= FIFO not full)
s_last  in  NUM_SOURCES  per-source tlast
s_data  in  DATA_WIDTH*NUM_SOURCES  flattened tdata; source i at [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
m_valid  out  1  output tvalid (registered)
m_ready  in  1  output tready
m_last  out  1  output tlast (registered)
m_data  out  DATA_WIDTH  output tdata (registered)
m_tid  out  TID_WIDTH  index of the source owning the current beat
truncStrobe  out  NUM_SOURCES  1-cycle pulse per source when one of its packets is truncated

Behaviour:
- Reset (rst_n=0 at an edge):
  - All FIFOs are emptied; s_ready=0 while rst_n=0.
  - m_valid=0, m_last=0, m_data=0, m_tid=0, truncStrobe=0.
  - State=IDLE; round-robin pointer lastGrant=NUM_SOURCES-1, so source 0 has first priority.
  - Reset mid-packet discards all buffered and in-flight data; no partial packet is emitted afterwards.
- Input side:
  - A beat is written as {last,data} on an edge with s_valid[i]&&s_ready[i].
  - s_ready[i]=!full[i]; FIFOs never overflow.
  - Full and empty are exact at FIFO_DEPTH entries and 0 entries.
- Output register:
  - Loads when m_valid=0 or m_ready=1; holds while m_valid&&!m_ready.
  - m_data, m_last and m_tid are stable while stalled.
- FSM IDLE:
  - Eligible source i means FIFO i is non-empty and srcEnable[i]=1.
  - ARB_MODE=0: the winner is the first eligible index searching from (lastGrant+1) mod N upward with wrap.
  - ARB_MODE=1: the winner is the lowest eligible index.
  - On a win, grant and lastGrant are registered, the beat counter is cleared, and the FSM moves to STREAM. With no eligible source it stays in IDLE.
- FSM STREAM:
  - Pops FIFO[grant] whenever the output register can load and the FIFO is non-empty.
  - Each pop increments the beat counter.
  - Popping the last=1 beat returns the FSM to IDLE, giving 1 bubble cycle between packets.
  - An empty FIFO mid-packet stalls STREAM with m_valid dropping; the grant is held, so no interleaving occurs.
- Truncation (MAX_PKT_BEATS>0):
  - When the popped beat is number MAX_PKT_BEATS and its last=0, it is emitted with m_last forced to 1.
  - truncStrobe[grant] pulses for 1 cycle and the FSM enters DRAIN.
  - A packet exactly MAX_PKT_BEATS long ends normally with no strobe.
- FSM DRAIN: pops and discards FIFO[grant] beats (no output) until the last=1 beat is popped, then returns to IDLE.
- srcEnable:
  - Deasserting srcEnable[i] mid-packet does not abort the packet; it only blocks new grants.
  - A disabled FIFO keeps filling, then backpressures.
- Latency: a beat accepted into an empty FIFO while the FSM is IDLE and m_ready=1 gives m_valid=1 after the 2nd rising edge following acceptance.
- Simultaneous write and pop on the same FIFO in one edge are both performed, and the occupancy is unchanged.
- The beat counter saturates and does not wrap.

Test Plan:
1. Basic ordering: ARB_MODE=0, m_ready=1. Sources 0–3 each push a 4-beat packet in the same cycle, data 0xCACA00ii → output packets appear in source order 0,1,2,3. Each packet has 4 contiguous beats with m_tid constant and m_last on the 4th beat, and there is a 1-cycle gap between packets.
2. Fixed priority: ARB_MODE=1. Source 3 streams continuous 2-beat packets while source 1 has one pending packet → source 1 is granted at the next IDLE and source 3 resumes afterwards. With source 0 also pending, the order is 0, then 1, then 3.
3. Backpressure: m_ready toggles with 50% probability over 200 packets from 4 sources → zero lost, duplicated or interleaved beats, and m_data is stable during every stall. When FIFO 2 holds 8 beats, s_ready[2]=0.
4. Truncation: MAX_PKT_BEATS=3. Source 1 sends 6 beats D0..D5 → output is D0,D1,D2 with m_last on D2. truncStrobe[1] pulses once, D3..D5 are discarded, and the next 3-beat packet from source 1 passes intact with no strobe.
5. Enable mask: srcEnable=4'b1011 with source 2 holding 2 packets → source 2 is never granted and s_ready[2] drops at 8 beats. Raising srcEnable[2] makes both packets follow within the next round-robin cycle.
6. Reset mid-packet: rst_n=0 for 1 cycle during beat 2 of a 4-beat packet → m_valid=0 and all s_ready=0 during reset, and FIFOs are empty afterwards. The next fresh packet is output first with its own m_tid, and no stale beats appear.
